shift_unit_arbiter: RTL and testbench
=====================================

Name: shift_unit_arbiter

Overview:
Shares one 32-bit left barrel shifter (existing BitShiftLeft block) between two requesters, the ALU shift path (req0) and the load/store byte-alignment path (req1). Each requester uses a valid/ready handshake. The block provides SLL, SRL and SRA by bit-reversing around the left shifter. Results land in a single registered output stage with valid/ready backpressure to the writeback side.

Parameters:
FAIR, 1, 1 = round-robin between requesters; 0 = fixed priority, req0 always wins
RESET_PRIORITY, 0, requester that wins the first tie after reset (0 or 1); only meaningful when FAIR=1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_data  input  32  operand
req0_amount  input  5  shift amount 0..31
req0_op  input  2  shift_op_t
req1_valid, req1_ready, req1_data, req1_amount, req1_op  same as req0, for requester 1
resp_valid  output  1  result register holds a valid result
resp_ready  input  1  consumer takes the result this cycle
resp_data  output  32  shifted result
resp_id  output  1  index of the requester that produced resp_data

Behaviour:
- Reset (async assert, sync deassert by the system):
  - resp_valid=0, resp_data=0, resp_id=0
  - last_grant = !RESET_PRIORITY, so RESET_PRIORITY wins the first tie
  - Reset mid-operation discards the held result immediately; no replay.
- accept = !resp_valid || resp_ready. The output stage accepts a new operation when it is empty or draining this cycle. This is a pipelined full-throughput path: 1 result per cycle is sustainable.
- Grant is combinational:
  - only one valid: grant that one
  - both valid, FAIR=1: grant the requester != last_grant
  - both valid, FAIR=0: grant req0
- reqN_ready = accept && reqN_valid && (grant==N). ready never asserts without valid. At most one ready is high per cycle.
- Handshake rules:
  - reqN_valid must not depend on reqN_ready.
  - Once raised, valid/data/amount/op hold stable until ready; the bench asserts this.
- On transfer (reqN_valid && reqN_ready), at the next edge:
  - resp_data = result, resp_id = N, resp_valid = 1
  - last_grant = N; last_grant updates only on a transfer
- If accept && no request valid: resp_valid clears at the edge when resp_ready drained it.
- If resp_valid && !resp_ready: resp_data and resp_id hold bit-stable, and both readys are 0.
- Latency: exactly 1 cycle from transfer to resp_valid.
- Operation datapath (selected requester's fields):
  - SLL: shifter input = data, fill = 0, result = shifter output.
  - SRL: shifter input = reverse(data), fill = 0, result = reverse(shifter output).
  - SRA: as SRL, but fill = data[31].
  - PASS (2'b11): result = data; amount ignored; shifter enable is irrelevant.
  - amount = 0: result = data for all ops.
- Simultaneous resp_ready and a new transfer in the same cycle: old result consumed, new result registered, resp_valid stays 1.

Decomposition:
- Package shift_pkg holds:
  - SHIFT_WIDTH=32, SHIFT_AMOUNT_BITS=5
  - typedef enum logic[1:0] shift_op_t {SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_PASS=2'b11}
  - typedef struct packed shift_req_t {data, amount, op}
- Sub-module shift_bit_reverse (combinational, WIDTH parameter) is used twice, pre- and post-shifter.
- One BitShiftLeft instance is shared.
- Arbitration and output register stay in the top module.

Test Plan:
- req0 SLL data=0x00000001 amount=31, resp_ready=1 -> next cycle resp_valid=1, resp_data=0x80000000, resp_id=0.
- req1 SRA data=0x80000000 amount=4 -> resp_data=0xF8000000, resp_id=1. Then SRL of the same operand and amount -> resp_data=0x08000000. Then SRL amount=31 -> 0x00000001.
- Both valid continuously, FAIR=1, RESET_PRIORITY=0, resp_ready=1:
  - grants alternate 0,1,0,1 and resp_id alternates accordingly
  - one result per cycle, never two readys together
  - with FAIR=0, req0 granted every cycle and req1_ready stays 0
- Backpressure: result 0x12345678 PASS held with resp_ready=0 for 5 cycles -> resp_data/resp_id stable, req0_ready=req1_ready=0. Drop-in resp_ready=1 with new req0 valid -> back-to-back transfer, resp_valid stays 1.
- Boundary: amount=0 with each op on data 0xA5A5A5A5 -> result 0xA5A5A5A5. PASS with amount=17 -> 0xA5A5A5A5.
- Reset asserted asynchronously mid-cycle while resp_valid=1 and resp_ready=0 -> resp_valid=0 and resp_data=0 immediately without a clock edge. After release, the first tie is granted to RESET_PRIORITY.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, operation codes and request bundle for the shift unit.
package shift_pkg;
    localparam int SHIFT_WIDTH = 32;
    localparam int SHIFT_AMOUNT_BITS = 5;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_PASS = 2'b11
    } shift_op_t;

    typedef struct packed {
        logic [SHIFT_WIDTH-1:0]       data;
        logic [SHIFT_AMOUNT_BITS-1:0] amount;
        shift_op_t                    op;
    } shift_req_t;
endpackage

// File: rtl/BitShiftLeft.sv
// BitShiftLeft: left barrel shifter whose vacated low bits take the fill value.
module BitShiftLeft
    import shift_pkg::*;
(
    input  logic [SHIFT_WIDTH-1:0]       data,
    input  logic [SHIFT_AMOUNT_BITS-1:0] amount,
    input  logic                         fill,
    output logic [SHIFT_WIDTH-1:0]       result
);
    logic [SHIFT_WIDTH-1:0] ones;

    assign ones   = '1;
    assign result = (data << amount) | ({SHIFT_WIDTH{fill}} & ~(ones << amount));
endmodule

// File: rtl/shift_bit_reverse.sv
// shift_bit_reverse: mirrors bit order so a left shifter can perform right shifts.
module shift_bit_reverse #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] result
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign result[i] = data[WIDTH-1-i];
    end
endmodule

// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: arbitrates two requesters onto one left shifter and
// registers the result behind a valid/ready output stage.
module shift_unit_arbiter
    import shift_pkg::*;
#(
    parameter bit FAIR           = 1'b1,
    parameter bit RESET_PRIORITY = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req0_valid,
    output logic                         req0_ready,
    input  logic [SHIFT_WIDTH-1:0]       req0_data,
    input  logic [SHIFT_AMOUNT_BITS-1:0] req0_amount,
    input  logic [1:0]                   req0_op,
    input  logic                         req1_valid,
    output logic                         req1_ready,
    input  logic [SHIFT_WIDTH-1:0]       req1_data,
    input  logic [SHIFT_AMOUNT_BITS-1:0] req1_amount,
    input  logic [1:0]                   req1_op,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [SHIFT_WIDTH-1:0]       resp_data,
    output logic                         resp_id
);
    shift_req_t             req0, req1, sel;
    logic                   last_grant, grant, accept, fire, fill;
    logic [SHIFT_WIDTH-1:0] data_rev, shift_in, shift_out, out_rev, result;

    assign req0 = '{data: req0_data, amount: req0_amount, op: shift_op_t'(req0_op)};
    assign req1 = '{data: req1_data, amount: req1_amount, op: shift_op_t'(req1_op)};

    // Ties go to the requester not served last; otherwise whoever is valid.
    assign grant      = (req0_valid && req1_valid) ? (FAIR ? !last_grant : 1'b0) : req1_valid;
    assign accept     = !resp_valid || resp_ready;
    assign req0_ready = accept && req0_valid && !grant;
    assign req1_ready = accept && req1_valid && grant;
    assign fire       = req0_ready || req1_ready;
    assign sel        = grant ? req1 : req0;

    // Right shifts run as left shifts on the bit-reversed operand.
    shift_bit_reverse #(.WIDTH(SHIFT_WIDTH)) u_pre_rev (
        .data   (sel.data),
        .result (data_rev)
    );

    assign shift_in = (sel.op == SHIFT_SLL) ? sel.data : data_rev;
    assign fill     = (sel.op == SHIFT_SRA) && sel.data[SHIFT_WIDTH-1];

    BitShiftLeft u_shifter (
        .data   (shift_in),
        .amount (sel.amount),
        .fill   (fill),
        .result (shift_out)
    );

    shift_bit_reverse #(.WIDTH(SHIFT_WIDTH)) u_post_rev (
        .data   (shift_out),
        .result (out_rev)
    );

    assign result = (sel.op == SHIFT_PASS) ? sel.data :
                    (sel.op == SHIFT_SLL)  ? shift_out : out_rev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
            last_grant <= !RESET_PRIORITY;
        end else if (fire) begin
            resp_valid <= 1'b1;
            resp_data  <= result;
            resp_id    <= grant;
            last_grant <= grant;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter: random and directed stimulus checked every cycle against
// a behavioural model of the arbitrated shift unit.
module tb_shift_unit_arbiter;
    localparam bit FAIR = 1'b1;
    localparam bit RP   = 1'b0;

    logic        clk = 0, reset = 1;
    logic        req0_valid = 0, req1_valid = 0, resp_ready = 0;
    logic [31:0] req0_data = 0, req1_data = 0;
    logic [4:0]  req0_amount = 0, req1_amount = 0;
    logic [1:0]  req0_op = 0, req1_op = 0;
    logic        req0_ready, req1_ready, resp_valid, resp_id;
    logic [31:0] resp_data;
    logic        f_r0, f_r1, f_valid, f_id;
    logic [31:0] f_data;

    int vectors = 0, miscompares = 0;
    int p0 = 0, p1 = 0, pr = 100;
    bit took0 = 0, took1 = 0;

    logic        mv = 0, mid = 0, mlast = 1, fvm = 0;
    logic [31:0] md = 0, fexp = 0;
    logic        pv0 = 0, pv1 = 0;
    logic [31:0] pd0, pd1;
    logic [4:0]  pa0, pa1;
    logic [1:0]  po0, po1;

    always #5 clk = ~clk;

    shift_unit_arbiter #(.FAIR(FAIR), .RESET_PRIORITY(RP)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amount(req0_amount), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amount(req1_amount), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id)
    );

    shift_unit_arbiter #(.FAIR(1'b0), .RESET_PRIORITY(1'b1)) u_fix (
        .clk(clk), .reset(reset),
        .req0_valid(1'b1), .req0_ready(f_r0), .req0_data(req0_data),
        .req0_amount(req0_amount), .req0_op(req0_op),
        .req1_valid(1'b1), .req1_ready(f_r1), .req1_data(req1_data),
        .req1_amount(req1_amount), .req1_op(req1_op),
        .resp_valid(f_valid), .resp_ready(1'b1), .resp_data(f_data), .resp_id(f_id)
    );

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
        case (op)
            2'd0:    return d << a;
            2'd1:    return d >> a;
            2'd2:    return $unsigned($signed(d) >>> a);
            default: return d;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic acc, win, e0, e1;
        if (reset) begin
            mv = 0; md = 0; mid = 0; mlast = !RP; fvm = 0;
            pv0 = 0; pv1 = 0; took0 = 0; took1 = 0;
            chk("reset_valid", resp_valid, 0);
            chk("reset_data", resp_data, 0);
            chk("reset_id", resp_id, 0);
            chk("fix_reset_valid", f_valid, 0);
        end else begin
            if (pv0) chk("hold0", {req0_valid, req0_data, req0_amount, req0_op}, {1'b1, pd0, pa0, po0});
            if (pv1) chk("hold1", {req1_valid, req1_data, req1_amount, req1_op}, {1'b1, pd1, pa1, po1});
            acc = !mv || resp_ready;
            win = (req0_valid && req1_valid) ? (FAIR ? !mlast : 1'b0) : req1_valid;
            e0 = acc && req0_valid && !win;
            e1 = acc && req1_valid && win;
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("resp_valid", resp_valid, mv);
            if (mv) begin
                chk("resp_data", resp_data, md);
                chk("resp_id", resp_id, mid);
            end
            if (e0 || e1) begin
                mv = 1; mid = e1; mlast = e1;
                md = e1 ? ref_shift(req1_data, req1_amount, req1_op) : ref_shift(req0_data, req0_amount, req0_op);
            end else if (resp_ready) mv = 0;
            chk("fix_ready", {f_r0, f_r1}, 2'b10);
            if (fvm) begin
                chk("fix_valid", f_valid, 1);
                chk("fix_id", f_id, 0);
                chk("fix_data", f_data, fexp);
            end
            fvm = 1;
            fexp = ref_shift(req0_data, req0_amount, req0_op);
            took0 = req0_valid && req0_ready;
            took1 = req1_valid && req1_ready;
            pv0 = req0_valid && !req0_ready; pd0 = req0_data; pa0 = req0_amount; po0 = req0_op;
            pv1 = req1_valid && !req1_ready; pd1 = req1_data; pa1 = req1_amount; po1 = req1_op;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (!req0_valid || took0) begin
                req0_valid = $urandom_range(99) < p0;
                req0_data = $urandom; req0_amount = 5'($urandom); req0_op = 2'($urandom);
            end
            if (!req1_valid || took1) begin
                req1_valid = $urandom_range(99) < p1;
                req1_data = $urandom; req1_amount = 5'($urandom); req1_op = 2'($urandom);
            end
            resp_ready = $urandom_range(99) < pr;
        end
    endtask

    task automatic drain();
        p0 = 0; p1 = 0; pr = 100;
        cycles(6);
    endtask

    task automatic wait_ready(input bit n);
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = n ? req1_ready : req0_ready;
        end
        if (!got) chk("handshake_timeout", 0, 1);
    endtask

    task automatic issue(input bit n, input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                         input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        resp_ready = 1;
        if (n) begin req1_valid = 1; req1_data = d; req1_amount = a; req1_op = op; end
        else   begin req0_valid = 1; req0_data = d; req0_amount = a; req0_op = op; end
        wait_ready(n);
        @(posedge clk); #1;
        if (n) req1_valid = 0; else req0_valid = 0;
        @(negedge clk);
        chk({name, "_valid"}, resp_valid, 1);
        chk(name, resp_data, exp);
        chk({name, "_id"}, resp_id, n);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        issue(0, 32'h00000001, 31, 2'd0, 32'h80000000, "sll31");
        issue(1, 32'h80000000, 4, 2'd2, 32'hF8000000, "sra4");
        issue(1, 32'h80000000, 4, 2'd1, 32'h08000000, "srl4");
        issue(1, 32'h80000000, 31, 2'd1, 32'h00000001, "srl31");
        for (int op = 0; op < 4; op++) issue(op[0], 32'hA5A5A5A5, 0, 2'(op), 32'hA5A5A5A5, "amt0");
        issue(0, 32'hA5A5A5A5, 17, 2'd3, 32'hA5A5A5A5, "pass17");

        p0 = 100; p1 = 100; pr = 100;
        cycles(12);
        drain();

        @(posedge clk); #1;
        resp_ready = 1; req0_valid = 1; req0_data = 32'h12345678; req0_amount = 9; req0_op = 2'd3;
        wait_ready(0);
        @(posedge clk); #1;
        resp_ready = 0; req0_data = 32'h00000003; req0_amount = 1; req0_op = 2'd0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_data", resp_data, 32'h12345678);
            chk("bp_id", resp_id, 0);
            chk("bp_readys", {req0_ready, req1_ready}, 2'b00);
        end
        @(posedge clk); #1 resp_ready = 1;
        @(negedge clk) chk("bp_resume_ready", req0_ready, 1);
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
        chk("bp_b2b_valid", resp_valid, 1);
        chk("bp_b2b_data", resp_data, 32'h00000006);

        p0 = 60; p1 = 60; pr = 70;
        cycles(2000);
        drain();

        @(posedge clk); #1;
        resp_ready = 0; req0_valid = 1; req0_data = 32'hDEADBEEF; req0_amount = 3; req0_op = 2'd3;
        wait_ready(0);
        @(posedge clk); #1 req0_valid = 0;
        @(posedge clk); #3;
        chk("pre_reset_valid", resp_valid, 1);
        reset = 1;
        #1;
        chk("async_reset_valid", resp_valid, 0);
        chk("async_reset_data", resp_data, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 0; resp_ready = 1;
        req0_valid = 1; req0_data = $urandom; req0_amount = 5'($urandom); req0_op = 2'($urandom);
        req1_valid = 1; req1_data = $urandom; req1_amount = 5'($urandom); req1_op = 2'($urandom);
        @(negedge clk) chk("first_tie", {req0_ready, req1_ready}, 2'b10);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
